// File: rtl/pwd_lock_pkg.sv
// Shared types and constants for the keypad password lock.
// Holds the FSM state encoding, key width and the factory-default password.
package pwd_lock_pkg;

    localparam int KEY_W    = 2;
    localparam int NUM_KEYS = 4;

    // Factory password 0,1,2,3; digit i lives in bits [i*KEY_W +: KEY_W].
    localparam logic [NUM_KEYS*KEY_W-1:0] DEFAULT_PWD = {2'd3, 2'd2, 2'd1, 2'd0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_SET,
        ST_LOCKOUT
    } state_t;

    function automatic logic [KEY_W-1:0] default_digit(input int idx);
        return DEFAULT_PWD[(idx % NUM_KEYS)*KEY_W +: KEY_W];
    endfunction

endpackage

// File: rtl/pwd_lock_ctrl_if.sv
// Keypad and status bundle between the lock controller and its user side.
// The master drives the keys and set_mode; the slave (controller) drives status.
interface pwd_lock_ctrl_if;
    import pwd_lock_pkg::*;

    logic [NUM_KEYS-1:0] btn;
    logic                set_mode;
    logic                unlock;
    logic                alarm;
    logic                err;
    logic                set_done;
    logic [2:0]          digit_cnt;

    modport master (
        output btn, set_mode,
        input  unlock, alarm, err, set_done, digit_cnt
    );

    modport slave (
        input  btn, set_mode,
        output unlock, alarm, err, set_done, digit_cnt
    );

endinterface

// File: rtl/pwd_lock_ctrl_key_event.sv
// Rising-edge key detector: one event per cycle in which exactly one key goes down.
// Simultaneous presses and held keys produce nothing.
module key_event
    import pwd_lock_pkg::*;
(
    input  logic                myclk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] btn,
    output logic                evt,
    output logic [KEY_W-1:0]    key
);

    logic [NUM_KEYS-1:0] btn_q_reg;
    logic [NUM_KEYS-1:0] rise;
    logic [KEY_W-1:0]    idx_terms [NUM_KEYS];

    always_ff @(posedge myclk or posedge rst) begin
        if (rst) begin
            btn_q_reg <= '0;
        end else begin
            btn_q_reg <= btn;
        end
    end

    assign rise = btn & ~btn_q_reg;
    // Nonzero with a single bit set: clearing the lowest set bit leaves nothing.
    assign evt  = (rise != '0) && ((rise & (rise - {{(NUM_KEYS-1){1'b0}}, 1'b1})) == '0);

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_idx
            assign idx_terms[gi] = rise[gi] ? KEY_W'(gi) : '0;
        end
    endgenerate

    always_comb begin
        key = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            key = key | idx_terms[i];
        end
    end

endmodule

// File: rtl/pwd_lock_ctrl.sv
// Keypad password lock: collects digits, checks them, opens, allows re-keying,
// and locks out after repeated wrong entries.
module pwd_lock_ctrl
    import pwd_lock_pkg::*;
#(
    parameter int PWD_LEN       = 4,
    parameter int MAX_FAIL      = 3,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int LOCK_TICKS    = 6000
)(
    input  logic            myclk,
    input  logic            rst,
    pwd_lock_ctrl_if.slave  bus
);

    localparam int CNT_W  = $clog2(PWD_LEN) + 1;
    localparam int FAIL_W = $clog2(MAX_FAIL) + 1;
    localparam int TO_W   = $clog2(TIMEOUT_TICKS) + 1;
    localparam int LK_W   = $clog2(LOCK_TICKS) + 1;

    logic             evt;
    logic [KEY_W-1:0] key;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [FAIL_W-1:0] fail_reg, fail_next;
    logic [TO_W-1:0]  to_reg, to_next;
    logic [LK_W-1:0]  lk_reg, lk_next;
    logic [KEY_W-1:0] entry_reg [PWD_LEN];
    logic [KEY_W-1:0] entry_next [PWD_LEN];
    logic [KEY_W-1:0] pwd_reg [PWD_LEN];
    logic [KEY_W-1:0] pwd_next [PWD_LEN];
    logic             err_reg, err_next;
    logic             set_done_reg, set_done_next;
    logic             unlock_reg, alarm_reg;

    logic [PWD_LEN-1:0] digit_eq;
    logic             match, timeout, last_digit, set_collect;

    key_event u_key_event (
        .myclk (myclk),
        .rst   (rst),
        .btn   (bus.btn),
        .evt   (evt),
        .key   (key)
    );

    generate
        for (genvar gi = 0; gi < PWD_LEN; gi++) begin : g_cmp
            assign digit_eq[gi] = (entry_reg[gi] == pwd_reg[gi]);
        end
    endgenerate

    assign match       = &digit_eq;
    assign timeout     = (to_reg == TO_W'(TIMEOUT_TICKS));
    assign last_digit  = (cnt_reg == CNT_W'(PWD_LEN - 1));
    assign set_collect = evt && ((state_reg == ST_SET) ||
                                 (state_reg == ST_OPEN && bus.set_mode));

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        fail_next     = fail_reg;
        pwd_next      = pwd_reg;
        err_next      = 1'b0;
        set_done_next = 1'b0;
        // The scratch buffer takes every key at the current index; it is only
        // compared or committed after a complete in-order fill, so stray writes are harmless.
        entry_next    = entry_reg;
        for (int i = 0; i < PWD_LEN; i++) begin
            if (evt && cnt_reg == CNT_W'(i)) begin
                entry_next[i] = key;
            end
        end

        case (state_reg)
            ST_IDLE, ST_ENTRY: begin
                if (evt) begin
                    if (last_digit) begin
                        state_next = ST_CHECK;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_ENTRY;
                        cnt_next   = cnt_reg + CNT_W'(1);
                    end
                end else if (state_reg == ST_ENTRY && timeout) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            ST_CHECK: begin
                cnt_next = '0;
                if (match) begin
                    state_next = ST_OPEN;
                    fail_next  = '0;
                end else begin
                    err_next   = 1'b1;
                    fail_next  = fail_reg + FAIL_W'(1);
                    state_next = (fail_reg == FAIL_W'(MAX_FAIL - 1)) ? ST_LOCKOUT : ST_IDLE;
                end
            end
            ST_OPEN, ST_SET: begin
                if (set_collect) begin
                    if (last_digit) begin
                        pwd_next      = entry_next;
                        set_done_next = 1'b1;
                        state_next    = ST_OPEN;
                        cnt_next      = '0;
                    end else begin
                        state_next = ST_SET;
                        cnt_next   = cnt_reg + CNT_W'(1);
                    end
                end else if (evt) begin
                    state_next = ST_IDLE;
                end else if (timeout) begin
                    state_next = (state_reg == ST_SET) ? ST_OPEN : ST_IDLE;
                    cnt_next   = '0;
                end
            end
            ST_LOCKOUT: begin
                if (lk_reg == LK_W'(LOCK_TICKS - 1)) begin
                    state_next = ST_IDLE;
                    fail_next  = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        if (evt || state_next != state_reg) begin
            to_next = '0;
        end else if (!timeout) begin
            to_next = to_reg + TO_W'(1);
        end else begin
            to_next = to_reg;
        end

        lk_next = (state_reg == ST_LOCKOUT) ? lk_reg + LK_W'(1) : '0;
    end

    always_ff @(posedge myclk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            fail_reg     <= '0;
            to_reg       <= '0;
            lk_reg       <= '0;
            err_reg      <= 1'b0;
            set_done_reg <= 1'b0;
            unlock_reg   <= 1'b0;
            alarm_reg    <= 1'b0;
            for (int i = 0; i < PWD_LEN; i++) begin
                entry_reg[i] <= '0;
                pwd_reg[i]   <= default_digit(i);
            end
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            fail_reg     <= fail_next;
            to_reg       <= to_next;
            lk_reg       <= lk_next;
            err_reg      <= err_next;
            set_done_reg <= set_done_next;
            unlock_reg   <= (state_next == ST_OPEN);
            alarm_reg    <= (state_next == ST_LOCKOUT);
            entry_reg    <= entry_next;
            pwd_reg      <= pwd_next;
        end
    end

    assign bus.unlock    = unlock_reg;
    assign bus.alarm     = alarm_reg;
    assign bus.err       = err_reg;
    assign bus.set_done  = set_done_reg;
    assign bus.digit_cnt = 3'(cnt_reg);

endmodule
